// File: rtl/mux_pkg.sv
// Shared types and constants for the mux_16x1 serializer front end.
package mux_pkg;

    localparam int unsigned IN_LENGTH  = 16;
    localparam int unsigned SEL_LENGTH = 4;
    localparam int unsigned CNT_W      = SEL_LENGTH + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    typedef logic [SEL_LENGTH-1:0] sel_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    // A length of 0 or anything beyond the word width means "whole word".
    function automatic cnt_t clamp_len(input cnt_t len);
        if ((len == '0) || (len > CNT_W'(IN_LENGTH))) begin
            return CNT_W'(IN_LENGTH);
        end
        return len;
    endfunction

endpackage

// File: rtl/sel_stepper.sv
// Loadable up/down counter driving the mux select; wraps modulo 2**SEL_LENGTH.
module sel_stepper
    import mux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  sel_t load_val,
    input  logic en,
    input  logic dir,
    output sel_t sel
);

    // Load has priority over stepping; dir=1 counts down.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '0;
        end else if (load) begin
            sel <= load_val;
        end else if (en) begin
            sel <= dir ? sel - SEL_LENGTH'(1) : sel + SEL_LENGTH'(1);
        end
    end

endmodule

// File: rtl/mux_serializer_ctrl.sv
// Parallel-to-serial controller: holds a word on the mux inputs and sweeps sel.
module mux_serializer_ctrl
    import mux_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_LENGTH-1:0]  word_in,
    input  logic [CNT_W-1:0]      word_len,
    input  logic                  msb_first,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [SEL_LENGTH-1:0] sel,
    output logic [IN_LENGTH-1:0]  mux_in,
    output logic                  mux_rstn,
    output logic                  bit_valid,
    output logic                  bit_last,
    input  logic                  bit_ready,
    output logic                  busy
);

    ser_state_t           state_q;
    ser_state_t           state_d;
    cnt_t                 rem_q;
    cnt_t                 rem_d;
    logic [IN_LENGTH-1:0] mux_in_q;
    logic                 dir_q;
    logic                 accept;
    logic                 xfer;
    cnt_t                 len_c;
    sel_t                 load_val;

    // Qualifiers are decoded straight from the registered state.
    assign bit_valid  = (state_q == SHIFT);
    assign bit_last   = bit_valid && (rem_q == CNT_W'(1));
    assign mux_rstn   = bit_valid;
    assign busy       = bit_valid;
    assign mux_in     = mux_in_q;

    // Ready in IDLE, or on the final transfer so back-to-back words see no bubble.
    assign word_ready = !rst && ((state_q == IDLE) || (bit_last && bit_ready));
    assign accept     = word_valid && word_ready;
    assign xfer       = bit_valid && bit_ready;

    assign len_c      = clamp_len(word_len);
    assign load_val   = msb_first ? SEL_LENGTH'(len_c - CNT_W'(1)) : '0;

    // Select counter holds after the last bit unless a new word reloads it.
    sel_stepper u_sel_stepper (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (load_val),
        .en       (xfer && !bit_last),
        .dir      (dir_q),
        .sel      (sel)
    );

    // Next state and remaining-bit count.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (accept) begin
            state_d = SHIFT;
            rem_d   = len_c;
        end else if (xfer) begin
            rem_d = rem_q - CNT_W'(1);
            if (bit_last) begin
                state_d = IDLE;
            end
        end
    end

    // State, counter and latched word; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            mux_in_q <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (accept) begin
                mux_in_q <= word_in;
                dir_q    <= msb_first;
            end
        end
    end

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Directed bench for mux_serializer_ctrl with a behavioural mux_16x1 on its outputs.
module tb_mux_serializer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_in;
    logic [4:0]  word_len;
    logic        msb_first;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  sel;
    logic [15:0] mux_in;
    logic        mux_rstn;
    logic        bit_valid;
    logic        bit_last;
    logic        bit_ready;
    logic        busy;
    logic        serial;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_serializer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_len   (word_len),
        .msb_first  (msb_first),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .sel        (sel),
        .mux_in     (mux_in),
        .mux_rstn   (mux_rstn),
        .bit_valid  (bit_valid),
        .bit_last   (bit_last),
        .bit_ready  (bit_ready),
        .busy       (busy)
    );

    // mux_16x1 behaviour: selected input while enabled, 0 in reset.
    assign serial = mux_rstn ? mux_in[sel] : 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one word, optionally stalling at one select value, and check every bit.
    task automatic run_word(input logic [15:0] w, input logic [4:0] len, input logic msb,
                            input int stall_sel, input int stall_n, input string nm);
        int n;
        int es;
        int transfers;
        int stalled;
        n = ((len == 5'd0) || (len > 5'd16)) ? 16 : int'(len);
        word_in    = w;
        word_len   = len;
        msb_first  = msb;
        word_valid = 1'b1;
        bit_ready  = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        word_in    = ~w;
        word_len   = 5'd3;
        msb_first  = ~msb;
        es         = msb ? n - 1 : 0;
        transfers  = 0;
        stalled    = 0;
        for (int c = 0; (c < n + stall_n + 4) && (transfers < n); c++) begin
            check({nm, "_sel"}, 32'(sel), 32'(es));
            check({nm, "_valid"}, 32'(bit_valid), 32'd1);
            check({nm, "_busy"}, 32'(busy), 32'd1);
            check({nm, "_bit"}, 32'(serial), 32'(w[es]));
            check({nm, "_last"}, 32'(bit_last), 32'(transfers == n - 1));
            if ((es == stall_sel) && (stalled < stall_n)) begin
                bit_ready = 1'b0;
                stalled++;
            end else begin
                bit_ready = 1'b1;
            end
            #1;
            check({nm, "_wready"}, 32'(word_ready), 32'((transfers == n - 1) && bit_ready));
            if (bit_ready) begin
                transfers++;
                es = msb ? (es - 1) & 15 : (es + 1) & 15;
            end
            @(negedge clk);
        end
        bit_ready = 1'b1;
        check({nm, "_count"}, 32'(transfers), 32'(n));
        check({nm, "_idle_valid"}, 32'(bit_valid), 32'd0);
        check({nm, "_idle_rstn"}, 32'(mux_rstn), 32'd0);
        check({nm, "_idle_bit"}, 32'(serial), 32'd0);
        check({nm, "_idle_mux_in"}, 32'(mux_in), 32'(w));
    endtask

    initial begin
        logic [15:0] exp_w;
        rst        = 1'b1;
        word_in    = 16'h0;
        word_len   = 5'd0;
        msb_first  = 1'b0;
        word_valid = 1'b0;
        bit_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_wready", 32'(word_ready), 32'd0);
        check("rst_valid", 32'(bit_valid), 32'd0);
        check("rst_last", 32'(bit_last), 32'd0);
        check("rst_rstn", 32'(mux_rstn), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_mux_in", 32'(mux_in), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_wready", 32'(word_ready), 32'd1);
        @(negedge clk);

        run_word(16'hA5C3, 5'd16, 1'b0, -1, 0, "lsb_full");
        run_word(16'h000B, 5'd4, 1'b1, -1, 0, "msb_short");
        run_word(16'hFFFF, 5'd16, 1'b0, 5, 3, "stall");

        // Back-to-back: second word waits on word_valid and loads on the first bit_last.
        word_in    = 16'h00FF;
        word_len   = 5'd16;
        msb_first  = 1'b0;
        word_valid = 1'b1;
        @(negedge clk);
        word_in = 16'hFF00;
        for (int i = 0; i < 32; i++) begin
            exp_w = (i < 16) ? 16'h00FF : 16'hFF00;
            if (i == 16) word_valid = 1'b0;
            check("b2b_valid", 32'(bit_valid), 32'd1);
            check("b2b_sel", 32'(sel), 32'(i % 16));
            check("b2b_bit", 32'(serial), 32'(exp_w[i % 16]));
            check("b2b_last", 32'(bit_last), 32'((i % 16) == 15));
            @(negedge clk);
        end
        check("b2b_idle", 32'(bit_valid), 32'd0);

        // Reset in the middle of a word.
        word_in    = 16'h1234;
        word_len   = 5'd16;
        msb_first  = 1'b0;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; (i < 20) && (sel != 4'd7); i++) @(negedge clk);
        check("mid_sel7", 32'(sel), 32'd7);
        rst = 1'b1;
        #1;
        check("mid_rst_wready", 32'(word_ready), 32'd0);
        @(negedge clk);
        check("mid_valid", 32'(bit_valid), 32'd0);
        check("mid_sel", 32'(sel), 32'd0);
        check("mid_mux_in", 32'(mux_in), 32'd0);
        check("mid_rstn", 32'(mux_rstn), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_wready_after", 32'(word_ready), 32'd1);
        @(negedge clk);
        run_word(16'h1234, 5'd16, 1'b0, -1, 0, "after_rst");

        run_word(16'h8001, 5'd0, 1'b1, -1, 0, "clamp0");
        run_word(16'h8001, 5'd20, 1'b1, -1, 0, "clamp20");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mux_serializer_ctrl.md
Name: mux_serializer_ctrl

Overview:
- Upstream control stage for mux_16x1. Turns the mux into a parallel-to-serial converter.
- Accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Sweeps the 4-bit select one bit per accepted cycle and drives the mux enable. The serial bit is the mux output, qualified by bit_valid/bit_last with downstream back-pressure via bit_ready.

Parameters:
- IN_LENGTH, 16, width of the data word and of mux_in.
- SEL_LENGTH, 4, width of sel; IN_LENGTH == 2**SEL_LENGTH.
- CNT_W, SEL_LENGTH+1, width of word_len and the internal remaining-bits counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- word_in  input  IN_LENGTH  word to serialize, sampled on accept.
- word_len  input  CNT_W  bits to send, sampled on accept; 0 or >IN_LENGTH means IN_LENGTH.
- msb_first  input  1  sampled on accept; 1 = start at bit word_len-1 and step down, 0 = start at bit 0 and step up.
- word_valid  input  1  upstream word available.
- word_ready  output  1  block can accept a word this cycle.
- sel  output  SEL_LENGTH  to mux_16x1 sel.
- mux_in  output  IN_LENGTH  to mux_16x1 in; the latched word.
- mux_rstn  output  1  to mux_16x1 rstn; high only while in SHIFT.
- bit_valid  output  1  mux output is a valid serial bit.
- bit_last  output  1  current bit is the final bit of the word.
- bit_ready  input  1  downstream consumes the bit this cycle.
- busy  output  1  high in SHIFT.

Behaviour:
- Reset:
  - With rst high at an edge: state=IDLE; sel, mux_in and remaining count = 0; mux_rstn, bit_valid and bit_last = 0.
  - word_ready is forced 0 combinationally while rst is high.
  - Reset mid-word drops the word; there is no partial completion.
- States: IDLE, SHIFT.
- Accept: occurs on word_valid && word_ready.
  - word_ready = (state==IDLE) || (state==SHIFT && bit_last && bit_ready). This is a combinational path from bit_ready, which is allowed.
- On accept, at the next edge:
  - Latch mux_in=word_in.
  - len = clamped word_len.
  - sel = msb_first ? len-1 : 0.
  - remaining = len.
  - Store the direction.
  - state=SHIFT.
- In SHIFT:
  - bit_valid=1, mux_rstn=1, busy=1, bit_last=(remaining==1). These are combinational from registered state.
- Transfer: occurs on bit_valid && bit_ready.
  - remaining decrements.
  - sel steps +1 (LSB-first) or -1 (MSB-first).
  - sel wraps modulo 2**SEL_LENGTH. Wrap is never reached by a legal sequence, but arithmetic is plain modulo.
- Stall: bit_ready low holds sel, remaining, mux_in and all outputs stable.
- Last transfer without a new accept: state goes to IDLE; sel and mux_in hold their values; mux_rstn drops to 0, so the mux output reads 0.
- Last transfer with a simultaneous accept (back-to-back): reload exactly as in accept and stay in SHIFT, with no idle bubble.
- Latency: accept at edge N gives the first bit valid in cycle N+1, because the mux is combinational.
  - Full word with bit_ready tied high: len cycles of bit_valid.
  - Throughput: one bit/cycle sustained with back-to-back words.
- Input changes on word_in, word_len and msb_first outside accept are ignored.
- word_valid while busy and not on the last transfer is not accepted; upstream must hold it.

Decomposition:
- Package mux_pkg holds:
  - IN_LENGTH and SEL_LENGTH localparams, replacing the macros going forward.
  - typedef enum logic {IDLE, SHIFT} ser_state_t.
  - typedef logic [SEL_LENGTH-1:0] sel_t.
  - The len-clamp function.
- One sub-module, sel_stepper: a loadable SEL_LENGTH-bit up/down counter with load, load_val, en and dir inputs.
- The FSM, remaining counter and handshake logic stay in mux_serializer_ctrl.
- Top-level test harness instantiates mux_serializer_ctrl feeding mux_16x1.

Test Plan:
- LSB-first full word: word_in=16'hA5C3, word_len=16, msb_first=0, bit_ready=1.
  - sel steps 0..15.
  - Mux output stream is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - bit_last only at sel=15; word_ready=1 in that cycle; IDLE next with mux_rstn=0.
- MSB-first short word: word_in=16'h000B, word_len=4, msb_first=1.
  - sel goes 3,2,1,0.
  - Bits are 1,0,1,1.
  - Exactly 4 bit_valid cycles; bit_last on sel=0.
- Back-pressure: 16'hFFFF, LSB-first, bit_ready low for 3 cycles at sel=5.
  - sel stays 5, bit_valid stays 1, output stays 1.
  - Total transfers = 16.
- Back-to-back: word_valid held high with 16'h00FF then 16'hFF00, bit_ready=1.
  - 32 consecutive valid bits with no gap.
  - Second word's sel restarts at 0 the cycle after the first bit_last.
- Reset mid-word: assert rst for 1 cycle at sel=7 of 16'h1234.
  - Next cycle: IDLE, bit_valid=0, sel=0, mux_in=0, mux_rstn=0.
  - word_ready=0 during rst and 1 after.
  - A new word then serializes from sel=0.
- Length clamp: word_len=0 and word_len=20 with 16'h8001, MSB-first.
  - Both send 16 bits starting at sel=15.
  - First bit 1, last bit 1, middle 14 bits 0.
